spi_aes_slave: RTL and testbench
================================

Name: spi_aes_slave

Overview:
- SPI slave front-end of the AES core; sits directly downstream of the SPI master on the serial link.
- Deserialises one command frame: mode byte, 128-bit block and Nk*32-bit key. Launches the AES core, then returns the 128-bit result to the master in a following read transaction.
- All SPI pins are oversampled in the single system clock domain.

Parameters:
- Nk, 8, key length in 32-bit words; legal values 4, 6, 8.
- FRAME_BITS, 8+128+Nk*32, write-frame length in bits; derived, do not override.

Ports:
- clk  in  1  system clock; must be at least 4x the sclk frequency.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master; CPOL=0, CPHA=0.
- cs_n  in  1  SPI chip select, active low.
- mosi  in  1  serial data from master, MSB first.
- miso  out  1  serial data to master, MSB first.
- core_sel_encrypt  out  1  1 = encrypt, 0 = decrypt; valid while core_start is high and held after it.
- core_data  out  128  block to AES core.
- core_key  out  Nk*32  key to AES core.
- core_start  out  1  one-cycle launch pulse.
- core_done  in  1  AES core completion strobe.
- core_result  in  128  AES core output; sampled when core_done=1.
- busy  out  1  high in BUSY.
- result_valid  out  1  high in READY and TX.
- frame_err  out  1  one-cycle pulse on an aborted write frame.

Behaviour:
- Input sync: sclk, cs_n and mosi each pass through 2-flop synchronisers. sclk_rise and sclk_fall are derived from the synchronised sclk and its previous value. cs_fall and cs_rise are derived the same way.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; bit counter = 0; shift registers = 0.
  - miso=0, core_start=0, busy=0, result_valid=0, frame_err=0.
  - core_data, core_key and core_sel_encrypt = 0.
- Bit counter: 9 bits, wide enough for FRAME_BITS ≤ 392.
- IDLE:
  - On cs_fall, go to RX and clear the counter.
- RX (write frame):
  - On each sclk_rise with cs_n low, shift mosi into the LSB of the FRAME_BITS shift register and increment the counter.
  - Frame bit order: mode byte first (bit0 of the byte = encrypt, bits 7:1 ignored), then data[127:0], then key[Nk*32-1:0].
  - When the counter reaches FRAME_BITS:
    - Load core_data, core_key and core_sel_encrypt.
    - Pulse core_start for exactly 1 cycle, on the cycle after the last shift.
    - Go to BUSY.
  - Further sclk edges before cs_rise are ignored.
  - cs_rise before FRAME_BITS: pulse frame_err for 1 cycle, discard the partial frame, go to IDLE; core outputs are unchanged.
- BUSY:
  - busy=1; cs_n activity and sclk are ignored; miso=0.
  - On core_done, latch core_result into the TX register and go to READY.
  - If core_done and cs_fall occur in the same cycle, the latch happens and cs_fall is ignored; the master must reassert.
- READY:
  - result_valid=1.
  - On cs_fall: drive miso = result[127] from the following cycle, clear the counter, go to TX.
- TX (read frame):
  - On each sclk_fall with cs_n low, advance miso to the next bit (MSB to LSB) and increment the counter. mosi is ignored.
  - After 128 bits have been presented, miso holds 0.
  - On cs_rise after a full 128 bits: result_valid=0, go to IDLE.
  - On cs_rise before 128 bits: go to READY with the result retained, so the next read restarts from bit 127.
- miso is 0 in every state other than TX.
- Reset mid-frame or mid-BUSY aborts everything asynchronously. Any later core_done is ignored until the next write frame completes.
- core_done while in IDLE, RX, READY or TX is ignored.

Test Plan:
- Encrypt, Nk=8: write frame with mode 0x01, data 00112233445566778899aabbccddeeff, key 000102…1e1f. Expect one core_start pulse with matching core_data, core_key and core_sel_encrypt=1. A bench core model returns 8ea2b7ca516745bfeafc49904b496089 → a 128-bit read returns exactly that value and result_valid falls at cs_rise.
- Decrypt, Nk=8: mode 0x00, data 8ea2b7ca516745bfeafc49904b496089, same key → core_sel_encrypt=0; read returns 00112233445566778899aabbccddeeff.
- Aborted write: cs_n rises after 100 bits → frame_err pulses once, no core_start, state IDLE; a following full frame works normally.
- Partial read: cs_n rises after 40 read bits → result_valid stays 1; the next full read returns all 128 bits from the MSB.
- Busy lockout: cs_n toggled with 50 sclk cycles while the core has not yet asserted done → no state change, miso=0, no frame_err; after core_done, the read is correct.
- Async reset: rst=0 mid-TX at bit 60 → all outputs 0 immediately. Reassert core_done after release → result_valid stays 0.

Source files
------------

// File: rtl/spi_aes_slave.sv
// spi_aes_slave: SPI slave (CPOL=0, CPHA=0) front-end of the AES core. It receives a
// {mode, block, key} write frame, launches the core, and returns the 128-bit result
// during a later read frame. The SPI pins are oversampled in the clk domain.
// Ports: clk, rst (async, active low); sclk, cs_n, mosi, miso (SPI link);
// core_sel_encrypt, core_data, core_key, core_start, core_done, core_result (AES core);
// busy, result_valid, frame_err (status).
module spi_aes_slave #(
  parameter int Nk = 8,
  localparam int FRAME_BITS = 8 + 128 + Nk * 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              core_sel_encrypt,
  output logic [127:0]      core_data,
  output logic [Nk*32-1:0]  core_key,
  output logic              core_start,
  input  logic              core_done,
  input  logic [127:0]      core_result,
  output logic              busy,
  output logic              result_valid,
  output logic              frame_err
);
  // The shift register holds only data+key. Mode bits 7:1 drop off the top, and
  // mode bit 0 is taken from the widened next value on the final shift.
  localparam int SR_BITS = FRAME_BITS - 8;
  localparam logic [8:0] LAST_BIT = 9'(FRAME_BITS - 1);
  localparam logic [8:0] TX_BITS = 9'd128;
  typedef enum logic [2:0] {IDLE, RX, BUSY, READY, TX} state_t;
  state_t state, state_next;
  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic rx_shift, rx_last, tx_shift;
  logic [8:0] cnt;
  logic [SR_BITS-1:0] sr;
  logic [SR_BITS:0] frame_next;
  logic [127:0] res, tx_sh;
  always_comb begin
    sclk_rise = sclk_sync[1] & ~sclk_d;
    sclk_fall = ~sclk_sync[1] & sclk_d;
    cs_fall = ~cs_sync[1] & cs_d;
    cs_rise = cs_sync[1] & ~cs_d;
    frame_next = {sr, mosi_sync[1]};
    rx_shift = state == RX && sclk_rise && !cs_sync[1];
    rx_last = rx_shift && cnt == LAST_BIT;
    tx_shift = state == TX && sclk_fall && !cs_sync[1] && cnt != TX_BITS;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = cs_fall ? RX : IDLE;
      RX:      state_next = rx_last ? BUSY : cs_rise ? IDLE : RX;
      BUSY:    state_next = core_done ? READY : BUSY;
      READY:   state_next = cs_fall ? TX : READY;
      TX:      state_next = !cs_rise ? TX : cnt == TX_BITS ? IDLE : READY;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    busy = state == BUSY;
    result_valid = state == READY || state == TX;
    miso = state == TX && tx_sh[127];
  end
  // cs_n synchronisers reset to the idle (high) level so release never looks like a select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync <= 2'b11;
      mosi_sync <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b1;
      cnt <= '0;
      sr <= '0;
      res <= '0;
      tx_sh <= '0;
      core_start <= 1'b0;
      frame_err <= 1'b0;
      core_sel_encrypt <= 1'b0;
      core_data <= '0;
      core_key <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d <= sclk_sync[1];
      cs_d <= cs_sync[1];
      core_start <= rx_last;
      frame_err <= state == RX && cs_rise && !rx_last;
      if (state == IDLE && cs_fall) begin
        cnt <= '0;
        sr <= '0;
      end
      if (rx_shift) begin
        sr <= frame_next[SR_BITS-1:0];
        cnt <= cnt + 9'd1;
      end
      if (rx_last) begin
        core_sel_encrypt <= frame_next[SR_BITS];
        core_data <= frame_next[Nk*32 +: 128];
        core_key <= frame_next[Nk*32-1:0];
      end
      if (state == BUSY && core_done) res <= core_result;
      if (state == READY && cs_fall) begin
        tx_sh <= res;
        cnt <= '0;
      end
      if (tx_shift) begin
        tx_sh <= {tx_sh[126:0], 1'b0};
        cnt <= cnt + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_spi_aes_slave.sv
// tb_spi_aes_slave: scoreboard bench for spi_aes_slave driving SPI frames and a simple core model.
module tb_spi_aes_slave;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic clk = 1'b0;
  logic rst, sclk, cs_n, mosi, miso;
  logic core_sel_encrypt, core_start, core_done, busy, result_valid, frame_err;
  logic [127:0] core_data, core_result;
  logic [255:0] core_key;
  int n_checks = 0;
  int n_pass = 0;
  int start_cyc = 0;
  int ferr_cyc = 0;
  int miso_hi = 0;
  logic cap_enc = 1'b0;
  logic [127:0] cap_data = '0;
  logic [255:0] cap_key = '0;
  logic [127:0] exp_q[$];
  spi_aes_slave #(.Nk(8)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .core_sel_encrypt(core_sel_encrypt), .core_data(core_data), .core_key(core_key),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .busy(busy), .result_valid(result_valid), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (core_start) begin
      start_cyc++;
      cap_enc = core_sel_encrypt;
      cap_data = core_data;
      cap_key = core_key;
    end
    if (frame_err) ferr_cyc++;
    if (miso) miso_hi++;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic logic [127:0] aes_ref(input logic enc, input logic [127:0] data);
    if (enc && data == PT) return CT;
    if (!enc && data == CT) return PT;
    return ~data;
  endfunction
  task automatic check_zero(input string p);
    check({p, "_miso"}, 256'(miso), 256'd0);
    check({p, "_busy"}, 256'(busy), 256'd0);
    check({p, "_result_valid"}, 256'(result_valid), 256'd0);
    check({p, "_frame_err"}, 256'(frame_err), 256'd0);
    check({p, "_core_start"}, 256'(core_start), 256'd0);
    check({p, "_sel_encrypt"}, 256'(core_sel_encrypt), 256'd0);
    check({p, "_core_data"}, 256'(core_data), 256'd0);
    check({p, "_core_key"}, core_key, 256'd0);
  endtask
  task automatic spi_write(input logic [7:0] mode, input logic [127:0] data, input logic [255:0] key, input int nbits);
    logic [391:0] frame;
    frame = {mode, data, key};
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[391-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic spi_read(input int n, input bit release_cs, output logic [127:0] got);
    got = '0;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      got = {got[126:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    if (release_cs) begin
      repeat (2) @(negedge clk);
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask
  task automatic core_respond();
    repeat (6) @(negedge clk);
    core_result = aes_ref(cap_enc, cap_data);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic full_read(input string tag);
    logic [127:0] got, exp;
    spi_read(128, 1'b1, got);
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 128'hx;
    check({tag, "_data"}, 256'(got), 256'(exp));
    check({tag, "_rv_low"}, 256'(result_valid), 256'd0);
  endtask
  initial begin
    int s0, f0, m0;
    logic [127:0] got, ctv;
    ctv = CT;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; core_done = 1'b0; core_result = '0;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    s0 = start_cyc;
    spi_write(8'h01, PT, KEY, 392);
    exp_q.push_back(aes_ref(1'b1, PT));
    check("enc_start", 256'(start_cyc - s0), 256'd1);
    check("enc_data", 256'(cap_data), 256'(PT));
    check("enc_key", cap_key, KEY);
    check("enc_sel", 256'(cap_enc), 256'd1);
    check("enc_busy", 256'(busy), 256'd1);
    core_respond();
    check("enc_rv", 256'(result_valid), 256'd1);
    check("enc_sel_held", 256'(core_sel_encrypt), 256'd1);
    full_read("enc_read");
    s0 = start_cyc;
    spi_write(8'h00, CT, KEY, 392);
    exp_q.push_back(aes_ref(1'b0, CT));
    check("dec_start", 256'(start_cyc - s0), 256'd1);
    check("dec_data", 256'(cap_data), 256'(CT));
    check("dec_sel", 256'(cap_enc), 256'd0);
    core_respond();
    full_read("dec_read");
    s0 = start_cyc;
    f0 = ferr_cyc;
    spi_write(8'h01, PT, KEY, 100);
    check("abort_ferr", 256'(ferr_cyc - f0), 256'd1);
    check("abort_start", 256'(start_cyc - s0), 256'd0);
    check("abort_busy", 256'(busy), 256'd0);
    check("abort_rv", 256'(result_valid), 256'd0);
    check("abort_data_kept", 256'(core_data), 256'(CT));
    s0 = start_cyc;
    spi_write(8'hfe, PT, KEY, 392);
    exp_q.push_back(aes_ref(1'b0, PT));
    check("after_abort_start", 256'(start_cyc - s0), 256'd1);
    check("after_abort_data", 256'(cap_data), 256'(PT));
    check("after_abort_sel", 256'(cap_enc), 256'd0);
    core_respond();
    full_read("after_abort_read");
    spi_write(8'h01, PT, KEY, 392);
    exp_q.push_back(aes_ref(1'b1, PT));
    core_respond();
    spi_read(40, 1'b1, got);
    check("partial_bits", 256'(got[39:0]), 256'(ctv[127:88]));
    check("partial_rv", 256'(result_valid), 256'd1);
    full_read("partial_then_full");
    spi_write(8'h00, CT, KEY, 392);
    exp_q.push_back(aes_ref(1'b0, CT));
    f0 = ferr_cyc;
    m0 = miso_hi;
    s0 = start_cyc;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      mosi = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("lock_busy", 256'(busy), 256'd1);
    check("lock_rv", 256'(result_valid), 256'd0);
    check("lock_ferr", 256'(ferr_cyc - f0), 256'd0);
    check("lock_miso", 256'(miso_hi - m0), 256'd0);
    check("lock_start", 256'(start_cyc - s0), 256'd0);
    core_respond();
    full_read("lock_read");
    spi_write(8'h01, PT, KEY, 392);
    exp_q.push_back(aes_ref(1'b1, PT));
    core_respond();
    spi_read(60, 1'b0, got);
    check("rst_tx_bits", 256'(got[59:0]), 256'(ctv[127:68]));
    rst = 1'b0;
    #1 check_zero("rst_tx");
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    core_result = CT;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    repeat (4) @(negedge clk);
    check("late_done_rv", 256'(result_valid), 256'd0);
    check("late_done_busy", 256'(busy), 256'd0);
    check("queue_empty", 256'(exp_q.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
